// File: rtl/colorizer_pipe.sv
// ============================================================================
// Module   : colorizer_pipe
// Purpose  : Two-stage pixel colorizer that merges prioritised icon layers over
//            a programmable world-map palette and blanks outside active video.
//            Optional icon blinking is enabled by defining COLORIZER_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module colorizer_pipe #(
  parameter int COLOR_W      = 12,
  parameter int WORLD_W      = 2,
  parameter int NUM_ICONS    = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WORLD_W-1:0]             worldIn,
  input  logic [NUM_ICONS*COLOR_W-1:0]   iconIn,
  input  logic                           enableVideo,
  input  logic                           vsync,
  input  logic [NUM_ICONS-1:0]           blinkMask,
  input  logic                           palWe,
  input  logic [WORLD_W-1:0]             palAddr,
  input  logic [COLOR_W-1:0]             palData,
  output logic [COLOR_W-1:0]             drawColor,
  output logic                           blinkPhase
);

  localparam int CH   = COLOR_W / 3;
  localparam int NPAL = 2 ** WORLD_W;

  localparam logic [COLOR_W-1:0] c_white = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] c_black = {COLOR_W{1'b0}};
  localparam logic [COLOR_W-1:0] c_green = {{CH{1'b0}}, {CH{1'b1}}, {CH{1'b0}}};
  localparam logic [COLOR_W-1:0] c_red   = {{CH{1'b1}}, {(2*CH){1'b0}}};

  function automatic logic [COLOR_W-1:0] pal_default(input int idx);
    case (idx)
      0:       pal_default = c_white;
      2:       pal_default = c_green;
      3:       pal_default = c_red;
      default: pal_default = c_black;
    endcase
  endfunction

  // Palette storage
  logic [COLOR_W-1:0] pal_q [NPAL];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else if (palWe) begin
      pal_q[palAddr] <= palData;
    end
  end

  // Stage 1 capture
  logic [WORLD_W-1:0]           world_q;
  logic [NUM_ICONS*COLOR_W-1:0] icon_q;
  logic                         en_q;
  logic [NUM_ICONS-1:0]         hid_q;
  logic [NUM_ICONS-1:0]         hid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      world_q <= '0;
      icon_q  <= '0;
      en_q    <= 1'b0;
      hid_q   <= '0;
    end else begin
      world_q <= worldIn;
      icon_q  <= iconIn;
      en_q    <= enableVideo;
      hid_q   <= hid_d;
    end
  end

  // Stage 2 select: scanning from the lowest-priority layer up lets layer 0 win.
  logic [COLOR_W-1:0] draw_d;
  logic [COLOR_W-1:0] draw_q;

  always_comb begin
    draw_d = pal_q[world_q];
    for (int k = NUM_ICONS - 1; k >= 0; k--) begin
      if ((icon_q[k*COLOR_W +: COLOR_W] != '0) && !hid_q[k]) begin
        draw_d = icon_q[k*COLOR_W +: COLOR_W];
      end
    end
    if (!en_q) begin
      draw_d = c_black;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draw_q <= c_black;
    end else begin
      draw_q <= draw_d;
    end
  end

  assign drawColor = draw_q;

`ifdef COLORIZER_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          vs_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          phase_q;
  logic          phase_d;
  logic          vs_rise;

  assign vs_rise = vsync & ~vs_prev_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (vs_rise) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Previous-vsync resets high so a vsync already asserted at reset is not a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q <= 1'b1;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
    end else begin
      vs_prev_q <= vsync;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign hid_d      = {NUM_ICONS{phase_q}} & blinkMask;
  assign blinkPhase = phase_q;
`else
  logic w_unused_ok;

  assign w_unused_ok = &{1'b0, vsync, blinkMask};
  assign hid_d       = '0;
  assign blinkPhase  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_colorizer_pipe.sv
// ============================================================================
// Module   : tb_colorizer_pipe
// Purpose  : Self-checking bench for colorizer_pipe with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_colorizer_pipe;

  localparam int CW = 12;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    worldIn = '0;
  logic [23:0]   iconIn = '0;
  logic          enableVideo = 1'b0;
  logic          vsync = 1'b0;
  logic [1:0]    blinkMask = '0;
  logic          palWe = 1'b0;
  logic [1:0]    palAddr = '0;
  logic [11:0]   palData = '0;
  logic [11:0]   drawColor;
  logic          blinkPhase;

  int n_checks = 0;
  int n_fail   = 0;

  colorizer_pipe #(
    .COLOR_W(CW), .WORLD_W(2), .NUM_ICONS(2), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .worldIn(worldIn), .iconIn(iconIn),
    .enableVideo(enableVideo), .vsync(vsync), .blinkMask(blinkMask),
    .palWe(palWe), .palAddr(palAddr), .palData(palData),
    .drawColor(drawColor), .blinkPhase(blinkPhase)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [11:0] m_pal [4];
  logic [1:0]  m_world;
  logic [11:0] m_icon [2];
  logic        m_en;
  logic [1:0]  m_hid;
  logic [11:0] m_draw;
  logic        m_phase;
  int          m_frames;
  logic        m_prev;

  task automatic model_reset();
    m_pal[0] = 12'hFFF; m_pal[1] = 12'h000; m_pal[2] = 12'h0F0; m_pal[3] = 12'hF00;
    m_world = 0; m_icon[0] = 0; m_icon[1] = 0; m_en = 0; m_hid = 0;
    m_draw = 0; m_phase = 0; m_frames = 0; m_prev = 1;
  endtask

  task automatic model_edge();
    logic [11:0] nd;
    bit found;
    found = 0;
    nd = m_pal[m_world];
    for (int k = 0; k < 2; k++) begin
      if (!found && m_icon[k] != 0 && !m_hid[k]) begin
        nd = m_icon[k];
        found = 1;
      end
    end
    if (!m_en) nd = 12'h000;
    m_draw  = nd;
    m_world = worldIn;
    m_icon[0] = iconIn[11:0];
    m_icon[1] = iconIn[23:12];
    m_en    = enableVideo;
`ifdef COLORIZER_BLINK_EN
    m_hid = m_phase ? blinkMask : 2'b00;
    if (vsync && !m_prev) begin
      m_frames = m_frames + 1;
      if (m_frames == BF) begin
        m_frames = 0;
        m_phase  = ~m_phase;
      end
    end
    m_prev = vsync;
`else
    m_hid = 2'b00;
`endif
    if (palWe) m_pal[palAddr] = palData;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic pulse();
    vsync = 1'b1; cyc();
    vsync = 1'b0; cyc(); cyc();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; #1;
    n_checks++;
    if (drawColor !== 12'h000) begin
      n_fail++; $display("FAIL reset_draw: got %h want 000", drawColor);
    end
    n_checks++;
    if (blinkPhase !== 1'b0) begin
      n_fail++; $display("FAIL reset_phase: got %b want 0", blinkPhase);
    end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_palette_defaults();
    logic [11:0] want [4];
    want[0] = 12'hFFF; want[1] = 12'h000; want[2] = 12'h0F0; want[3] = 12'hF00;
    enableVideo = 1'b1; iconIn = '0;
    for (int w = 0; w < 4; w++) begin
      worldIn = 2'(w);
      cyc(); cyc();
      n_checks++;
      if (drawColor !== want[w]) begin
        n_fail++; $display("FAIL default_pal[%0d]: got %h want %h", w, drawColor, want[w]);
      end
    end
  endtask

  task automatic test_enable();
    enableVideo = 1'b0; worldIn = 2'd0; iconIn = {12'h000, 12'h00F};
    cyc(); cyc();
    n_checks++;
    if (drawColor !== 12'h000) begin
      n_fail++; $display("FAIL blank: got %h want 000", drawColor);
    end
    enableVideo = 1'b1;
    cyc();
    n_checks++;
    if (drawColor !== 12'h000) begin
      n_fail++; $display("FAIL enable_lat1: got %h want 000", drawColor);
    end
    cyc();
    n_checks++;
    if (drawColor !== 12'h00F) begin
      n_fail++; $display("FAIL enable_lat2: got %h want 00F", drawColor);
    end
  endtask

  task automatic test_priority();
    enableVideo = 1'b1; worldIn = 2'd0;
    iconIn = {12'hF0F, 12'h00F}; cyc(); cyc();
    n_checks++;
    if (drawColor !== 12'h00F) begin
      n_fail++; $display("FAIL prio_both: got %h want 00F", drawColor);
    end
    iconIn = {12'hF0F, 12'h000}; cyc(); cyc();
    n_checks++;
    if (drawColor !== 12'hF0F) begin
      n_fail++; $display("FAIL prio_icon1: got %h want F0F", drawColor);
    end
    iconIn = '0; worldIn = 2'd2; cyc(); cyc();
    n_checks++;
    if (drawColor !== 12'h0F0) begin
      n_fail++; $display("FAIL prio_world: got %h want 0F0", drawColor);
    end
  endtask

  task automatic test_palette_write();
    apply_reset();
    enableVideo = 1'b1; iconIn = '0; worldIn = 2'd1;
    cyc();
    palWe = 1'b1; palAddr = 2'd1; palData = 12'h123;
    cyc();
    palWe = 1'b0;
    n_checks++;
    if (drawColor !== 12'h000) begin
      n_fail++; $display("FAIL palwr_old: got %h want 000", drawColor);
    end
    cyc();
    n_checks++;
    if (drawColor !== 12'h123) begin
      n_fail++; $display("FAIL palwr_new: got %h want 123", drawColor);
    end
    apply_reset();
    cyc(); cyc();
    n_checks++;
    if (drawColor !== 12'h000) begin
      n_fail++; $display("FAIL palwr_rereset: got %h want 000", drawColor);
    end
  endtask

  task automatic test_blink();
    apply_reset();
    enableVideo = 1'b1; worldIn = 2'd1; blinkMask = 2'b01;
    iconIn = {12'hF0F, 12'h00F};
    pulse(); pulse();
`ifdef COLORIZER_BLINK_EN
    n_checks++;
    if (blinkPhase !== 1'b1) begin
      n_fail++; $display("FAIL blink_on: got %b want 1", blinkPhase);
    end
    cyc(); cyc();
    n_checks++;
    if (drawColor !== 12'hF0F) begin
      n_fail++; $display("FAIL blink_hidden: got %h want F0F", drawColor);
    end
    pulse(); pulse(); cyc(); cyc();
    n_checks++;
    if (blinkPhase !== 1'b0 || drawColor !== 12'h00F) begin
      n_fail++; $display("FAIL blink_off: got %b/%h want 0/00F", blinkPhase, drawColor);
    end
    vsync = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    vsync = 1'b0; cyc();
    n_checks++;
    if (blinkPhase !== 1'b0) begin
      n_fail++; $display("FAIL vsync_hold: got %b want 0", blinkPhase);
    end
    pulse();
    n_checks++;
    if (blinkPhase !== 1'b1) begin
      n_fail++; $display("FAIL vsync_hold_once: got %b want 1", blinkPhase);
    end
`else
    cyc(); cyc();
    n_checks++;
    if (blinkPhase !== 1'b0 || drawColor !== 12'h00F) begin
      n_fail++; $display("FAIL noblink: got %b/%h want 0/00F", blinkPhase, drawColor);
    end
`endif
    blinkMask = 2'b00;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      worldIn     = 2'($urandom_range(0, 3));
      iconIn[11:0]  = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'h000;
      iconIn[23:12] = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'h000;
      enableVideo = ($urandom_range(0, 7) != 0);
      vsync       = ($urandom_range(0, 5) == 0);
      blinkMask   = 2'($urandom);
      palWe       = ($urandom_range(0, 4) == 0);
      palAddr     = 2'($urandom);
      palData     = 12'($urandom);
      cyc();
      n_checks++;
      if (drawColor !== m_draw || blinkPhase !== m_phase) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h/%b want %h/%b", i, drawColor, blinkPhase, m_draw, m_phase);
      end
    end
    palWe = 1'b0; vsync = 1'b0; blinkMask = 2'b00;
  endtask

  task automatic test_async_reset();
    apply_reset();
    enableVideo = 1'b1; worldIn = 2'd0; iconIn = '0;
    palWe = 1'b1; palAddr = 2'd0; palData = 12'h555;
    cyc();
    palWe = 1'b0;
    pulse(); pulse();
    n_checks++;
    if (drawColor !== 12'h555) begin
      n_fail++; $display("FAIL pre_reset: got %h want 555", drawColor);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (drawColor !== 12'h000 || blinkPhase !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h/%b want 000/0", drawColor, blinkPhase);
    end
    model_reset();
    #1;
    reset = 1'b0;
    cyc();
    n_checks++;
    if (drawColor !== 12'h000) begin
      n_fail++; $display("FAIL post_reset_lat: got %h want 000", drawColor);
    end
    cyc();
    n_checks++;
    if (drawColor !== 12'hFFF) begin
      n_fail++; $display("FAIL post_reset_pal: got %h want FFF", drawColor);
    end
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b0;
    test_reset();
    test_palette_defaults();
    test_enable();
    test_priority();
    test_palette_write();
    test_blink();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
